// File: rtl/vga_sync_to_count.sv
// Rebuilds column/row counters from active-low H/V sync pulses and checks
// that the incoming timing is steady before reporting lock.
module vga_sync_to_count #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_EDGE_COL = 640,
    parameter int V_EDGE_ROW = 480
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       H_pulse,
    input  logic       V_pulse,
    output logic       H_out,
    output logic       V_out,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       active,
    output logic       locked,
    output logic       err
);

    localparam int H_LEN_W = $clog2(2 * H_TOTAL + 1);
    localparam int V_LEN_W = $clog2(V_TOTAL + 2);

    localparam logic [H_LEN_W-1:0] H_LEN_ONE  = H_LEN_W'(1);
    localparam logic [H_LEN_W-1:0] H_LEN_GOOD = H_LEN_W'(H_TOTAL);
    localparam logic [H_LEN_W-1:0] H_LEN_MAX  = H_LEN_W'(2 * H_TOTAL);
    localparam logic [V_LEN_W-1:0] V_LEN_ONE  = V_LEN_W'(1);
    localparam logic [V_LEN_W-1:0] V_LEN_GOOD = V_LEN_W'(V_TOTAL);
    localparam logic [V_LEN_W-1:0] V_LEN_MAX  = V_LEN_W'(V_TOTAL + 1);

    localparam logic [9:0] COL_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] ROW_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] COL_EDGE = 10'(H_EDGE_COL);
    localparam logic [9:0] ROW_EDGE = 10'(V_EDGE_ROW);
    localparam logic [9:0] COL_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] ROW_VIS  = 10'(V_ACTIVE);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic               h_q, v_q;
    logic [9:0]         col_q, col_d;
    logic [9:0]         row_q, row_d;
    logic [H_LEN_W-1:0] h_len_q, h_len_d;
    logic [V_LEN_W-1:0] v_len_q, v_len_d;
    logic               bad_q, bad_d;
    state_t             state_q;
    logic               active_q, locked_q, err_q;

    logic h_edge, v_edge;
    logic line_good, line_bad, timeout, frame_good, col_wrap;

    always_comb begin
        h_edge     = h_q & ~H_pulse;
        v_edge     = v_q & ~V_pulse;
        line_good  = (h_len_q == H_LEN_GOOD);
        line_bad   = h_edge & ~line_good;
        timeout    = (h_len_q == H_LEN_MAX);
        frame_good = (v_len_q == V_LEN_GOOD) & ~bad_q;
        col_wrap   = ~h_edge & (col_q == COL_LAST);
    end

    // Column/row reconstruction runs in every state; the edges only re-align it.
    always_comb begin
        col_d = col_q + 10'd1;
        if (h_edge) begin
            col_d = COL_EDGE;
        end else if (col_wrap) begin
            col_d = 10'd0;
        end

        row_d = row_q;
        if (v_edge) begin
            row_d = ROW_EDGE;
        end else if (col_wrap) begin
            row_d = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
        end
    end

    // An H edge that lands on a V edge is the first line of the new frame.
    always_comb begin
        h_len_d = h_len_q;
        if (h_edge) begin
            h_len_d = H_LEN_ONE;
        end else if (!timeout) begin
            h_len_d = h_len_q + H_LEN_ONE;
        end

        v_len_d = v_len_q;
        bad_d   = bad_q | line_bad;
        if (v_edge) begin
            v_len_d = h_edge ? V_LEN_ONE : '0;
            bad_d   = line_bad;
        end else if (h_edge && (v_len_q != V_LEN_MAX)) begin
            v_len_d = v_len_q + V_LEN_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_q     <= 1'b1;
            v_q     <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
            h_len_q <= '0;
            v_len_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            h_q     <= H_pulse;
            v_q     <= V_pulse;
            col_q   <= col_d;
            row_q   <= row_d;
            h_len_q <= h_len_d;
            v_len_q <= v_len_d;
            bad_q   <= bad_d;
        end
    end

    // locked mirrors the state of the previous cycle, so err leads its fall by one clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= SEARCH;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            err_q    <= 1'b0;
            locked_q <= (state_q == LOCKED);
            active_q <= (state_q == LOCKED) && (col_d < COL_VIS) && (row_d < ROW_VIS);
            case (state_q)
                SEARCH: begin
                    if (!timeout && v_edge) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (timeout) begin
                        state_q <= SEARCH;
                    end else if (v_edge && frame_good) begin
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (timeout || line_bad || (v_edge && !frame_good)) begin
                        state_q <= SEARCH;
                        err_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SEARCH;
                end
            endcase
        end
    end

    assign H_out  = h_q;
    assign V_out  = v_q;
    assign col    = col_q;
    assign row    = row_q;
    assign active = active_q;
    assign locked = locked_q;
    assign err    = err_q;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Scoreboard bench: a small sync generator drives the DUT, a timestamp-based
// reference model predicts every output cycle, and a monitor compares.
module tb_vga_sync_to_count;

    localparam int HT  = 40;
    localparam int VT  = 12;
    localparam int HA  = 32;
    localparam int VA  = 9;
    localparam int HEC = 32;
    localparam int VER = 9;
    localparam int FRAME = HT * VT;

    localparam int S_SEARCH = 0;
    localparam int S_CHECK  = 1;
    localparam int S_LOCKED = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       H_pulse = 1'b1;
    logic       V_pulse = 1'b1;
    logic       H_out, V_out, active, locked, err;
    logic [9:0] col, row;

    vga_sync_to_count #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_EDGE_COL(HEC), .V_EDGE_ROW(VER)
    ) dut (
        .CLK(CLK), .RST(RST), .H_pulse(H_pulse), .V_pulse(V_pulse),
        .H_out(H_out), .V_out(V_out), .col(col), .row(row),
        .active(active), .locked(locked), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       h;
        logic       v;
        logic [9:0] col;
        logic [9:0] row;
        logic       act;
        logic       lck;
        logic       err;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: line length and column are derived from the time elapsed
    // since the last anchor (reset or H edge) rather than stepped counters.
    int m_cyc = 0, m_anchor = 0, m_len0 = 0, m_col0 = 0;
    int m_row = 0, m_lines = 0, m_state = S_SEARCH;
    bit m_bad = 0, m_hq = 1, m_vq = 1;

    function automatic obs_t model_step(bit h, bit v, bit rst);
        obs_t o;
        int el, len, cb, ca, ra, st;
        bit he, ve, good_line, tmo, good_frame;
        o = '0;
        m_cyc++;
        if (rst) begin
            m_anchor = m_cyc; m_len0 = 0; m_col0 = 0; m_row = 0;
            m_lines = 0; m_bad = 0; m_state = S_SEARCH; m_hq = 1; m_vq = 1;
            o.h = 1'b1; o.v = 1'b1;
            return o;
        end
        el  = m_cyc - 1 - m_anchor;
        len = m_len0 + el;
        if (len > 2 * HT) len = 2 * HT;
        cb  = (m_col0 + el) % HT;
        he  = m_hq && !h;
        ve  = m_vq && !v;
        good_line  = (len == HT);
        tmo        = (len == 2 * HT);
        good_frame = (m_lines == VT) && !m_bad;
        st = m_state;
        case (m_state)
            S_SEARCH: if (!tmo && ve) m_state = S_CHECK;
            S_CHECK: begin
                if (tmo) m_state = S_SEARCH;
                else if (ve && good_frame) m_state = S_LOCKED;
            end
            default: begin
                if (tmo || (he && !good_line) || (ve && !good_frame)) begin
                    m_state = S_SEARCH;
                    o.err = 1'b1;
                end
            end
        endcase
        ca = he ? HEC : (cb + 1) % HT;
        if (ve) ra = VER;
        else if (!he && cb == HT - 1) ra = (m_row + 1) % VT;
        else ra = m_row;
        if (he) begin
            m_anchor = m_cyc; m_len0 = 1; m_col0 = HEC;
        end
        if (ve) begin
            m_lines = he ? 1 : 0;
            m_bad   = he && !good_line;
        end else if (he) begin
            m_lines++;
            if (!good_line) m_bad = 1;
        end
        o.h   = h;
        o.v   = v;
        o.col = 10'(ca);
        o.row = 10'(ra);
        o.lck = (st == S_LOCKED);
        o.act = (st == S_LOCKED) && (ca < HA) && (ra < VA);
        m_row = ra; m_hq = h; m_vq = v;
        return o;
    endfunction

    // Sync generator: H low for g_hw cycles from column HEC, V low for g_vw lines from row VER.
    int g_col, g_row, g_hw, g_vw;
    int g_short_row = -1;
    int g_hold = 0;
    int g_frame_lines = VT;

    task automatic gen_drive();
        int len;
        H_pulse = !(g_hold == 0 && g_col >= HEC && g_col < HEC + g_hw);
        V_pulse = !(g_row >= VER && g_row < VER + g_vw);
        len = (g_row == g_short_row) ? HT - 1 : HT;
        if (g_col >= len - 1) begin
            g_col = 0;
            if (g_hold > 0) g_hold--;
            if (g_row == g_short_row) g_short_row = -1;
            g_row++;
            if (g_row >= g_frame_lines) begin
                g_row = 0;
                g_frame_lines = VT;
            end
        end else begin
            g_col++;
        end
    endtask

    task automatic step();
        gen_drive();
        exp_q.push_back(model_step(H_pulse, V_pulse, RST));
    endtask

    task automatic cycle();
        @(negedge CLK);
        #1;
        step();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(int n);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        n_tests++;
        if ({H_out, V_out, col, row, active, locked, err} !== {1'b1, 1'b1, 10'd0, 10'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL async_reset got h=%b v=%b col=%0d row=%0d act=%b lck=%b err=%b want 1 1 0 0 0 0 0",
                     H_out, V_out, col, row, active, locked, err);
        end
        step();
        run(n - 1);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        step();
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {H_out, V_out, col, row, active, locked, err};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_obs t=%0t got h=%b v=%b col=%0d row=%0d act=%b lck=%b err=%b want h=%b v=%b col=%0d row=%0d act=%b lck=%b err=%b",
                             $time, a.h, a.v, a.col, a.row, a.act, a.lck, a.err,
                             e.h, e.v, e.col, e.row, e.act, e.lck, e.err);
                end
            end
        end
    end

    initial begin : stimulus
        int budget;
        g_col = $urandom_range(0, HT - 1);
        g_row = $urandom_range(0, VT - 1);
        g_hw  = $urandom_range(2, 6);
        g_vw  = $urandom_range(1, 2);

        RST = 1'b1;
        run(3);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        step();

        // nominal lock, then a single short line
        run(3 * FRAME + 50);
        g_short_row = (g_row + 1 + $urandom_range(0, VT - 3)) % VT;
        run(4 * FRAME);

        // H sync disappears for two lines
        g_hold = 2;
        run(4 * FRAME);

        // asynchronous reset mid-line while locked
        run($urandom_range(1, HT - 1));
        do_reset($urandom_range(1, 3));

        // one short frame while checking, then a normal frame
        budget = 0;
        while (m_state != S_CHECK && budget < 3 * FRAME) begin
            cycle();
            budget++;
        end
        if (m_state != S_CHECK) begin
            n_tests++;
            n_fail++;
            $display("FAIL reach_check got state=%0d want %0d", m_state, S_CHECK);
        end
        g_frame_lines = VT - 1;
        run(3 * FRAME + 50);

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge CLK);
            budget++;
        end
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "bench did not finish");
    end

endmodule
